// File: rtl/change_dispenser.sv
// Change-payout engine: pays an amount out as 50/10/5/1 coins over a valid/ack
// hopper handshake. Picks greedily within per-denomination inventory and reports any unpaid remainder.
module change_dispenser #(
    parameter logic [7:0] INIT_CNT_50 = 8'd20,
    parameter logic [7:0] INIT_CNT_10 = 8'd20,
    parameter logic [7:0] INIT_CNT_5  = 8'd20,
    parameter logic [7:0] INIT_CNT_1  = 8'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       change_valid,
    input  logic [7:0] change_amount,
    output logic       change_ready,
    output logic [7:0] coin_out,
    output logic       coin_valid,
    input  logic       coin_ack,
    input  logic       refill_valid,
    input  logic [1:0] refill_denom,
    input  logic [7:0] refill_count,
    output logic       done,
    output logic [7:0] shortfall,
    output logic [1:0] state
);

    // state  | meaning
    // IDLE   | waiting for a change request
    // SELECT | choosing the next coin (one cycle)
    // EMIT   | coin offered, waiting for hopper ack
    // FINISH | done pulse, shortfall latched
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t     st;
    logic [7:0] remaining;
    logic [1:0] sel_idx;
    logic [7:0] cnt [4];
    logic [7:0] cnt_next [4];
    logic       found;
    logic [1:0] pick_idx;
    logic       dec_en;

    // Inventory index order is 0:50, 1:10, 2:5, 3:1 (matches refill_denom)
    function automatic logic [7:0] den_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'd50;
            2'd1:    return 8'd10;
            2'd2:    return 8'd5;
            default: return 8'd1;
        endcase
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign change_ready = (st == IDLE) && !reset;
    assign state        = st;
    assign dec_en       = (st == EMIT) && coin_valid && coin_ack;

    // Scan smallest to largest so the last hit is the largest usable coin
    always_comb begin
        found    = 1'b0;
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (den_of(2'(i)) <= remaining && cnt[i] != 8'd0) begin
                found    = 1'b1;
                pick_idx = 2'(i);
            end
        end
    end

    // Refill saturates first, then a same-cycle ack takes one coin off the result
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_next[i] = cnt[i];
            if (refill_valid && refill_denom == 2'(i))
                cnt_next[i] = sat_add(cnt[i], refill_count);
            if (dec_en && sel_idx == 2'(i))
                cnt_next[i] = cnt_next[i] - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            coin_valid <= 1'b0;
            coin_out   <= 8'd0;
            done       <= 1'b0;
            shortfall  <= 8'd0;
            remaining  <= 8'd0;
            sel_idx    <= 2'd0;
            cnt[0]     <= INIT_CNT_50;
            cnt[1]     <= INIT_CNT_10;
            cnt[2]     <= INIT_CNT_5;
            cnt[3]     <= INIT_CNT_1;
        end else begin
            for (int i = 0; i < 4; i++)
                cnt[i] <= cnt_next[i];
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (change_valid) begin
                        remaining <= change_amount;
                        shortfall <= 8'd0;
                        st        <= SELECT;
                    end
                end
                SELECT: begin
                    if (found) begin
                        coin_out   <= den_of(pick_idx);
                        coin_valid <= 1'b1;
                        sel_idx    <= pick_idx;
                        st         <= EMIT;
                    end else begin
                        done      <= 1'b1;
                        shortfall <= remaining;
                        st        <= FINISH;
                    end
                end
                EMIT: begin
                    if (coin_ack) begin
                        remaining  <= remaining - coin_out;
                        coin_valid <= 1'b0;
                        coin_out   <= 8'd0;
                        st         <= SELECT;
                    end
                end
                FINISH: begin
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a greedy coin/inventory model predicts each coin,
// the shortfall, the done timing and the inventory after every payout.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       change_ready;
    logic [7:0] coin_out;
    logic       coin_valid;
    logic       coin_ack;
    logic       refill_valid;
    logic [1:0] refill_denom;
    logic [7:0] refill_count;
    logic       done;
    logic [7:0] shortfall;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    int inv [4];
    int m_rem;

    change_dispenser dut (
        .clk(clk), .reset(reset),
        .change_valid(change_valid), .change_amount(change_amount), .change_ready(change_ready),
        .coin_out(coin_out), .coin_valid(coin_valid), .coin_ack(coin_ack),
        .refill_valid(refill_valid), .refill_denom(refill_denom), .refill_count(refill_count),
        .done(done), .shortfall(shortfall), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int den(input int idx);
        case (idx)
            0: return 50;
            1: return 10;
            2: return 5;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int greedy_pick(input int rem);
        for (int i = 0; i < 4; i++)
            if (den(i) <= rem && inv[i] > 0) return i;
        return -1;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic check_inventory(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_cnt%0d", tag, den(i)), dut.cnt[i], inv[i]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) inv[i] = 20;
        m_rem = 0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            if (change_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    // mode 0: immediate ack, 1: random ack/refills, 2: ack held low 5 cycles, 3: immediate ack + refill of 1-coins on each ack
    task automatic do_payout(input int amount, input int mode);
        int  cyc, exp_idx, held, coins, rd, rc;
        bit  ok, done_seen, ack, rf;
        wait_ready(ok);
        if (!ok) return;
        change_valid  = 1'b1;
        change_amount = 8'(amount);
        @(negedge clk);
        change_valid = 1'b0;
        m_rem = amount;
        cyc = 1; coins = 0; held = 0; done_seen = 0; exp_idx = -1;
        check("select_no_coin", coin_valid, 0);
        while (!done_seen && cyc < 400) begin
            coin_ack      = 1'b0;
            refill_valid  = 1'b0;
            change_valid  = ($urandom_range(0, 5) == 0);
            change_amount = 8'($urandom);
            if (done) begin
                check("shortfall", shortfall, m_rem);
                check("finish_state", state, 3);
                if (mode == 0 || mode == 3) check("done_cycle", cyc, 2 * coins + 2);
                done_seen = 1;
            end else if (coin_valid) begin
                if (held == 0) begin
                    exp_idx = greedy_pick(m_rem);
                    check("coin_value", coin_out, den(exp_idx));
                end else begin
                    check("coin_hold", coin_out, den(exp_idx));
                end
                case (mode)
                    1:       ack = ($urandom_range(0, 2) != 0);
                    2:       ack = (held >= 5);
                    default: ack = 1;
                endcase
                rf = 0; rd = 0; rc = 0;
                if (mode == 1 && $urandom_range(0, 5) == 0) begin
                    rf = 1; rd = $urandom_range(0, 3); rc = $urandom_range(0, 40);
                end else if (mode == 3 && ack) begin
                    rf = 1; rd = 3; rc = 10;
                end
                coin_ack     = ack;
                refill_valid = rf;
                refill_denom = 2'(rd);
                refill_count = 8'(rc);
                if (rf) inv[rd] = sat(inv[rd] + rc);
                if (ack) begin
                    if (exp_idx >= 0) begin
                        m_rem -= den(exp_idx);
                        inv[exp_idx]--;
                    end
                    coins++;
                    held = 0;
                end else begin
                    held++;
                end
            end else if (mode == 1) begin
                coin_ack = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        coin_ack = 1'b0; refill_valid = 1'b0; change_valid = 1'b0;
        if (!done_seen) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("done_pulse_end", done, 0);
        check("ready_after_done", change_ready, 1);
        check("shortfall_hold", shortfall, m_rem);
        check_inventory($sformatf("pay%0d", amount));
    endtask

    task automatic do_refill(input int d, input int c);
        refill_valid = 1'b1;
        refill_denom = 2'(d);
        refill_count = 8'(c);
        @(negedge clk);
        refill_valid = 1'b0;
        inv[d] = sat(inv[d] + c);
        check($sformatf("refill_cnt%0d", den(d)), dut.cnt[d], inv[d]);
    endtask

    initial begin
        bit ok;
        reset = 1'b1; change_valid = 1'b0; change_amount = 8'd0; coin_ack = 1'b0;
        refill_valid = 1'b0; refill_denom = 2'd0; refill_count = 8'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_coin_valid", coin_valid, 0);
        check("rst_coin_out", coin_out, 0);
        check("rst_done", done, 0);
        check("rst_shortfall", shortfall, 0);
        check("rst_ready_low", change_ready, 0);
        check_inventory("rst");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", change_ready, 1);

        do_payout(37, 0);
        do_payout(0, 0);
        do_payout(50, 2);
        do_refill(3, 250);
        do_payout(1, 3);
        do_payout(133, 1);

        // reset while a coin is being offered
        wait_ready(ok);
        change_valid = 1'b1; change_amount = 8'd60;
        @(negedge clk);
        change_valid = 1'b0;
        @(negedge clk);
        check("emit_coin_valid", coin_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check("abort_state", state, 0);
        check("abort_coin_valid", coin_valid, 0);
        check("abort_coin_out", coin_out, 0);
        check("abort_done", done, 0);
        check_inventory("abort");
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_done", done, 0);
        check("abort_ready", change_ready, 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                do_refill($urandom_range(0, 3), $urandom_range(0, 255));
            do_payout($urandom_range(0, 255), ($urandom_range(0, 3) == 0) ? 0 : 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-payout engine on the downstream side of the vending controller's `exchange` output. It accepts a change amount in IDLE and pays it out as individual coins (50/10/5/1) to a coin hopper, one coin per valid/ack handshake. Denominations are chosen greedily, limited by per-denomination inventory counters. It reports any unpayable remainder as `shortfall`. Inventory is refilled through a separate service port.

## Interface

- `INIT_CNT_50`, 8'd20, inventory of 50-coins after reset
- `INIT_CNT_10`, 8'd20, inventory of 10-coins after reset
- `INIT_CNT_5`, 8'd20, inventory of 5-coins after reset
- `INIT_CNT_1`, 8'd20, inventory of 1-coins after reset

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `change_valid`  in  1  change request present
- `change_amount`  in  8  amount to pay out; sampled on accept
- `change_ready`  out  1  combinational: `state==IDLE && !reset`
- `coin_out`  out  8  value of coin being ejected (50/10/5/1); 0 when `coin_valid`=0
- `coin_valid`  out  1  coin offered to hopper
- `coin_ack`  in  1  hopper has taken the coin
- `refill_valid`  in  1  inventory add request
- `refill_denom`  in  2  0:50, 1:10, 2:5, 3:1
- `refill_count`  in  8  coins to add
- `done`  out  1  one-cycle pulse at end of every payout
- `shortfall`  out  8  amount not paid by the last payout
- `state`  out  2  FSM state, for debug

## Operation

- States: IDLE=0, SELECT=1, EMIT=2, FINISH=3. Internal registers: `remaining`[7:0] and four 8-bit inventory counters.
- Reset (sync): state=IDLE, `coin_valid`=0, `coin_out`=0, `done`=0, `shortfall`=0, `remaining`=0, counters=INIT_CNT_*. Reset mid-payout aborts immediately. An in-flight coin is withdrawn without decrementing inventory.
- IDLE:
  - `change_valid`=1 → accept: `remaining`<=`change_amount`, `shortfall`<=0, go SELECT.
  - `change_amount`=0 is legal. It passes through SELECT to FINISH with zero coins.
- SELECT (exactly 1 cycle): pick the largest d in {50,10,5,1} with d<=`remaining` and cnt[d]>0.
  - Found → `coin_out`<=d, `coin_valid`<=1, go EMIT.
  - None found (including `remaining`=0) → go FINISH.
- EMIT:
  - `coin_valid` and `coin_out` hold stable until `coin_ack`=1.
  - On ack: `remaining`<=`remaining`-d, cnt[d]<=cnt[d]-1, `coin_valid`<=0, `coin_out`<=0, go SELECT.
  - No ack → stay indefinitely; there is no timeout.
- FINISH (1 cycle): `done`=1, `shortfall`=`remaining` (both registered on entry), then IDLE.
  - `done` returns to 0 on the next cycle.
  - `shortfall` holds until the next accept.
- Refill: applied in any state when `refill_valid`=1, cnt[denom]<=min(cnt+`refill_count`,255), saturating.
  - If a refill and an EMIT-ack decrement hit the same counter in the same cycle: result = sat(cnt+refill_count)-1.
- Ignored inputs:
  - `change_valid` outside IDLE (not queued).
  - `coin_ack` while `coin_valid`=0.
- Arithmetic: all 8-bit unsigned. `remaining` never underflows, because d<=`remaining` is guaranteed by SELECT.
- Greedy-with-inventory is the required algorithm, even when a non-greedy mix would pay exactly. Example: 15 with no 5-coins pays 10+1×5.

## Timing

- Accept at edge N (`change_valid`&&`change_ready`) → SELECT during cycle N+1 → `coin_valid` high from edge N+2.
- Per coin: minimum 2 cycles (EMIT with same-cycle ack, then SELECT).
- Payout of k coins with immediate ack: `done` is high during cycle N+2k+2 (k=0 → N+2); `change_ready` high again the following cycle.
- `coin_out`/`coin_valid` are registered, with no combinational path from `coin_ack`.

## Test plan

- Reset, then amount 37, full inventory, `coin_ack` tied 1 → coins 10,10,10,5,1,1; `done` once; `shortfall`=0; cnt10=17, cnt5=19, cnt1=18.
- Amount 0 → no `coin_valid`; `done` 2 cycles after accept; `shortfall`=0.
- INIT_CNT_5=0, INIT_CNT_1=3, amount 8 → coins 1,1,1; `shortfall`=5; cnt1=0.
- `coin_ack` held low 5 cycles, then pulsed → `coin_out` stable at 50 throughout; single decrement; `change_valid` pulses mid-payout are ignored.
- Refill denom 3 count 250 onto cnt1=20 → cnt1=255 (saturates). Refill coinciding with a 1-coin ack → 254.
- Reset asserted while in EMIT → next cycle IDLE, `coin_valid`=0, counters=INIT values, `done` not pulsed.
